// File: rtl/bpu_update_scheduler.sv
// rtl/bpu_update_scheduler.sv - queued read-modify-write scheduler for a single-ported predictor table
// Optional starvation guard enabled by defining BPU_UPD_STARVE_EN.
module bpu_update_scheduler #(
    parameter int DEPTH        = 4,
    parameter int UPD_W        = 64,
    parameter int IDX_W        = 8,
    parameter int ENT_W        = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [UPD_W-1:0]         upd_data,
    input  logic                     pred_req,
    output logic                     pred_grant,
    output logic                     sram_rd_en,
    output logic                     sram_wr_en,
    output logic [IDX_W-1:0]         sram_idx,
    input  logic [ENT_W-1:0]         sram_rd_data,
    output logic [ENT_W-1:0]         old_entry,
    output logic [UPD_W-1:0]         cur_upd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RESP,
        WR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [UPD_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;
    logic             access_ok;
    logic             force_upd;

    // Pointers carry a wrap bit so full and empty are distinguishable by subtraction.
    assign count     = wr_ptr - rd_ptr;
    assign upd_ready = (count != CW'(DEPTH));
    assign push      = upd_valid & upd_ready;
    assign pop       = sram_wr_en;
    assign cur_upd   = mem[rd_ptr[AW-1:0]];
    assign sram_idx  = cur_upd[IDX_W-1:0];
    assign busy      = (count != '0) | (state != IDLE);
    assign access_ok = ~pred_req | force_upd;
    assign pred_grant = pred_req & ~(sram_rd_en | sram_wr_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= upd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            old_entry <= '0;
        end else begin
            state <= state_nxt;
            if (state == RESP) old_entry <= sram_rd_data;
        end
    end

    // Head is popped only on the write strobe, so each RMW is atomic and in order.
    always_comb begin
        state_nxt  = state;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        case (state)
            IDLE: if (count != '0) state_nxt = RD;
            RD: begin
                sram_rd_en = access_ok;
                if (access_ok) state_nxt = RESP;
            end
            RESP: state_nxt = WR;
            WR: begin
                sram_wr_en = access_ok;
                if (access_ok) state_nxt = (count > CW'(1)) ? RD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BPU_UPD_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          force_hold;
    logic          denied;

    assign denied    = ((state == RD) | (state == WR)) & ~sram_rd_en & ~sram_wr_en;
    assign force_upd = (starve_cnt >= SW'(STARVE_LIMIT)) | force_hold;

    // force_hold carries a forced read through RESP so its write cannot starve again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            force_hold <= 1'b0;
        end else begin
            if (sram_rd_en | sram_wr_en)
                starve_cnt <= '0;
            else if (denied && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + {{(SW-1){1'b0}}, 1'b1};
            if (sram_wr_en)
                force_hold <= 1'b0;
            else if (sram_rd_en && force_upd)
                force_hold <= 1'b1;
        end
    end
`else
    assign force_upd = (STARVE_LIMIT < 0);
`endif

endmodule

// File: tb/tb_bpu_update_scheduler.sv
// tb/tb_bpu_update_scheduler.sv - directed self-checking bench for bpu_update_scheduler
module tb_bpu_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic        upd_ready;
    logic [63:0] upd_data;
    logic        pred_req;
    logic        pred_grant;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [7:0]  sram_idx;
    logic [31:0] sram_rd_data;
    logic [31:0] old_entry;
    logic [63:0] cur_upd;
    logic        busy;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit done   = 1'b0;

    always #5 clk = ~clk;

    bpu_update_scheduler #(
        .DEPTH(4), .UPD_W(64), .IDX_W(8), .ENT_W(32), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_data(upd_data),
        .pred_req(pred_req), .pred_grant(pred_grant),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_idx(sram_idx),
        .sram_rd_data(sram_rd_data), .old_entry(old_entry), .cur_upd(cur_upd),
        .busy(busy), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        if (!done) begin
            bad++;
            $error("FAIL timeout: test did not finish within the wait limit");
            $finish;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst === 1'b1) begin
            check("strobe_excl", 64'(sram_rd_en & sram_wr_en), 64'(1'b0));
            check("grant_excl", 64'(pred_grant & (sram_rd_en | sram_wr_en)), 64'(1'b0));
        end
    end

    initial begin
        rst = 1'b0; upd_valid = 1'b0; upd_data = '0; pred_req = 1'b0; sram_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'(3'd0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_ready", 64'(upd_ready), 64'(1'b1));
        check("rst_rd", 64'(sram_rd_en), 64'(1'b0));
        check("rst_wr", 64'(sram_wr_en), 64'(1'b0));
        check("rst_old", 64'(old_entry), 64'(32'h0));
        pred_req = 1'b1;
        #1;
        check("rst_grant", 64'(pred_grant), 64'(1'b1));
        pred_req = 1'b0;
        rst = 1'b1;
        chk_en = 1'b1;

        // single update
        upd_valid = 1'b1; upd_data = 64'h12; sram_rd_data = 32'hDEADBEEF;
        cyc(); upd_valid = 1'b0; #1;
        check("t1_count", 64'(count), 64'(3'd1));
        check("t1_busy", 64'(busy), 64'(1'b1));
        check("t1_cur", cur_upd, 64'h12);
        check("t1_no_rd_yet", 64'(sram_rd_en), 64'(1'b0));
        cyc(); #1;
        check("t1_rd", 64'(sram_rd_en), 64'(1'b1));
        check("t1_rd_idx", 64'(sram_idx), 64'(8'h12));
        cyc(); #1;
        check("t1_resp_rd", 64'(sram_rd_en), 64'(1'b0));
        check("t1_resp_wr", 64'(sram_wr_en), 64'(1'b0));
        cyc(); #1;
        check("t1_old", 64'(old_entry), 64'(32'hDEADBEEF));
        check("t1_wr", 64'(sram_wr_en), 64'(1'b1));
        check("t1_wr_idx", 64'(sram_idx), 64'(8'h12));
        cyc(); #1;
        check("t1_done_count", 64'(count), 64'(3'd0));
        check("t1_done_busy", 64'(busy), 64'(1'b0));

        // five back-to-back pushes into a four-entry queue
        sram_rd_data = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1; upd_data = 64'h20 + 64'(i);
            cyc();
        end
        upd_data = 64'h24; #1;
        check("t2_full_ready", 64'(upd_ready), 64'(1'b0));
        check("t2_full_count", 64'(count), 64'(3'd4));
        check("t2_first_wr", 64'(sram_wr_en), 64'(1'b1));
        check("t2_first_idx", 64'(sram_idx), 64'(8'h20));
        cyc(); #1;
        check("t2_pop_count", 64'(count), 64'(3'd3));
        check("t2_pop_ready", 64'(upd_ready), 64'(1'b1));
        for (int k = 1; k <= 4; k++) begin
            check("t2_rd", 64'(sram_rd_en), 64'(1'b1));
            check("t2_rd_idx", 64'(sram_idx), 64'(8'h20 + 8'(k)));
            cyc(); upd_valid = 1'b0; #1;
            check("t2_resp_idle", 64'(sram_rd_en | sram_wr_en), 64'(1'b0));
            cyc(); #1;
            check("t2_wr", 64'(sram_wr_en), 64'(1'b1));
            check("t2_wr_idx", 64'(sram_idx), 64'(8'h20 + 8'(k)));
            check("t2_old", 64'(old_entry), 64'(32'h1111_2222));
            check("t2_wr_count", 64'(count), 64'((k == 1) ? 3'd4 : 3'(5 - k)));
            cyc(); #1;
        end
        check("t2_done_count", 64'(count), 64'(3'd0));
        check("t2_done_busy", 64'(busy), 64'(1'b0));

        // prediction holds the port continuously
        pred_req = 1'b1; upd_valid = 1'b1; upd_data = 64'h33;
        cyc(); upd_valid = 1'b0; #1;
`ifdef BPU_UPD_STARVE_EN
        cyc(); #1;
        for (int i = 0; i < 8; i++) begin
            check("t3_denied_grant", 64'(pred_grant), 64'(1'b1));
            check("t3_denied_rd", 64'(sram_rd_en), 64'(1'b0));
            cyc(); #1;
        end
        check("t3_forced_rd", 64'(sram_rd_en), 64'(1'b1));
        check("t3_forced_grant", 64'(pred_grant), 64'(1'b0));
        cyc(); #1;
        check("t3_resp_grant", 64'(pred_grant), 64'(1'b1));
        check("t3_resp_idle", 64'(sram_rd_en | sram_wr_en), 64'(1'b0));
        cyc(); #1;
        check("t3_forced_wr", 64'(sram_wr_en), 64'(1'b1));
        check("t3_forced_wr_grant", 64'(pred_grant), 64'(1'b0));
        check("t3_forced_idx", 64'(sram_idx), 64'(8'h33));
        cyc(); #1;
        check("t3_grant_back", 64'(pred_grant), 64'(1'b1));
        check("t3_done_count", 64'(count), 64'(3'd0));
        pred_req = 1'b0;
`else
        for (int i = 0; i < 20; i++) begin
            check("t3_grant", 64'(pred_grant), 64'(1'b1));
            check("t3_no_strobe", 64'(sram_rd_en | sram_wr_en), 64'(1'b0));
            check("t3_busy", 64'(busy), 64'(1'b1));
            cyc(); #1;
        end
        pred_req = 1'b0; #1;
        check("t3_release_rd", 64'(sram_rd_en), 64'(1'b1));
        check("t3_release_idx", 64'(sram_idx), 64'(8'h33));
        cyc(); cyc(); #1;
        check("t3_release_wr", 64'(sram_wr_en), 64'(1'b1));
        cyc(); #1;
        check("t3_done_count", 64'(count), 64'(3'd0));
`endif

        // pred_req toggling during RD and WR
        upd_valid = 1'b1; upd_data = 64'h44;
        cyc(); upd_valid = 1'b0;
        cyc(); pred_req = 1'b1; #1;
        check("t4_rd_denied", 64'(sram_rd_en), 64'(1'b0));
        check("t4_rd_grant", 64'(pred_grant), 64'(1'b1));
        cyc(); pred_req = 1'b0; #1;
        check("t4_rd_fire", 64'(sram_rd_en), 64'(1'b1));
        check("t4_rd_nogrant", 64'(pred_grant), 64'(1'b0));
        cyc(); pred_req = 1'b1; #1;
        check("t4_resp_grant", 64'(pred_grant), 64'(1'b1));
        cyc(); #1;
        check("t4_wr_denied", 64'(sram_wr_en), 64'(1'b0));
        check("t4_wr_grant", 64'(pred_grant), 64'(1'b1));
        cyc(); pred_req = 1'b0; #1;
        check("t4_wr_fire", 64'(sram_wr_en), 64'(1'b1));
        check("t4_wr_idx", 64'(sram_idx), 64'(8'h44));
        cyc(); #1;
        check("t4_done_count", 64'(count), 64'(3'd0));

        // reset asserted during RESP with two queued updates
        sram_rd_data = 32'h5555_AAAA;
        upd_valid = 1'b1; upd_data = 64'h51;
        cyc(); upd_data = 64'h52;
        cyc(); upd_valid = 1'b0; #1;
        check("t5_rd", 64'(sram_rd_en), 64'(1'b1));
        check("t5_count", 64'(count), 64'(3'd2));
        cyc(); #1;
        check("t5_resp_busy", 64'(busy), 64'(1'b1));
        rst = 1'b0; #1;
        check("t5_rst_count", 64'(count), 64'(3'd0));
        check("t5_rst_busy", 64'(busy), 64'(1'b0));
        check("t5_rst_old", 64'(old_entry), 64'(32'h0));
        check("t5_rst_ready", 64'(upd_ready), 64'(1'b1));
        check("t5_rst_wr", 64'(sram_wr_en), 64'(1'b0));
        cyc(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_no_wr", 64'(sram_wr_en), 64'(1'b0));
            check("t5_still_empty", 64'(count), 64'(3'd0));
            cyc();
        end
        sram_rd_data = 32'hCAFE_F00D; upd_valid = 1'b1; upd_data = 64'h66;
        cyc(); upd_valid = 1'b0; #1;
        check("t5_new_count", 64'(count), 64'(3'd1));
        cyc(); #1;
        check("t5_new_rd", 64'(sram_rd_en), 64'(1'b1));
        check("t5_new_idx", 64'(sram_idx), 64'(8'h66));
        cyc(); cyc(); #1;
        check("t5_new_wr", 64'(sram_wr_en), 64'(1'b1));
        check("t5_new_old", 64'(old_entry), 64'(32'hCAFE_F00D));
        cyc(); #1;
        check("t5_new_done", 64'(busy), 64'(1'b0));

        chk_en = 1'b0;
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
